// File: rtl/jt6295_mixer.sv
// Four-voice attenuating mixer for the JT6295 ADPCM core.
// Each cen_sr4 slot contributes one attenuated voice sample. Slot 3 closes the
// period and publishes the saturated mix with a one-cycle valid pulse.
module jt6295_mixer #(
    parameter int OUTW = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen_sr4,
    input  logic            cen_sr,
    input  logic [11:0]     ch_sample,
    input  logic [3:0]      ch_att,
    input  logic            ch_active,
    output logic [1:0]      ch_idx,
    output logic [OUTW-1:0] sound,
    output logic            sample_valid
);

    // Clamp limits of the published sample, expressed in accumulator width.
    localparam logic signed [14:0] SAT_MAX = 15'((32'sd1 <<< (OUTW - 1)) - 32'sd1);
    localparam logic signed [14:0] SAT_MIN = -SAT_MAX - 15'sd1;

    // Attenuation index to linear gain (unity = 32); deep indices are muted.
    function automatic logic [5:0] gain_lut(input logic [3:0] att);
        logic [5:0] g;
        case (att)
            4'd0:    g = 6'd32;
            4'd1:    g = 6'd22;
            4'd2:    g = 6'd16;
            4'd3:    g = 6'd11;
            4'd4:    g = 6'd8;
            4'd5:    g = 6'd6;
            4'd6:    g = 6'd4;
            4'd7:    g = 6'd3;
            4'd8:    g = 6'd2;
            default: g = 6'd0;
        endcase
        return g;
    endfunction

    // Saturate the 15-bit mix into the OUTW-bit output range.
    function automatic logic [OUTW-1:0] sat(input logic signed [14:0] v);
        logic signed [14:0] c;
        if (v > SAT_MAX) begin
            c = SAT_MAX;
        end else if (v < SAT_MIN) begin
            c = SAT_MIN;
        end else begin
            c = v;
        end
        return c[OUTW-1:0];
    endfunction

    logic [1:0]         ch_idx_r;
    logic [1:0]         cur_slot_s;
    logic [5:0]         gain_s;
    logic signed [17:0] prod_s;
    logic signed [12:0] term_s;
    logic signed [14:0] sum_s;

    logic               p1_v_r;
    logic [1:0]         p1_tag_r;
    logic signed [12:0] p1_term_r;
    logic signed [14:0] acc_r;
    logic [OUTW-1:0]    sound_r;
    logic               valid_r;

    // Slot resolution and the scaled term of the voice presented this cycle.
    always_comb begin
        cur_slot_s = ch_idx_r;
        if (cen_sr) begin
            cur_slot_s = 2'd0;
        end else begin
            cur_slot_s = ch_idx_r;
        end
        gain_s = gain_lut(ch_att);
        prod_s = $signed({{6{ch_sample[11]}}, ch_sample}) * $signed({12'd0, gain_s});
        if (ch_active) begin
            term_s = 13'(prod_s >>> 5);
        end else begin
            term_s = 13'sd0;
        end
        sum_s = acc_r + {{2{p1_term_r[12]}}, p1_term_r};
    end

    // Slot counter: cen_sr realigns to slot 0, otherwise step and wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_idx_r <= 2'd0;
        end else if (cen_sr4) begin
            ch_idx_r <= cur_slot_s + 2'd1;
        end else begin
            ch_idx_r <= ch_idx_r;
        end
    end

    // Stage 1: capture the scaled term and its slot tag on each strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_v_r    <= 1'b0;
            p1_tag_r  <= 2'd0;
            p1_term_r <= 13'sd0;
        end else begin
            p1_v_r <= cen_sr4;
            if (cen_sr4) begin
                p1_tag_r  <= cur_slot_s;
                p1_term_r <= term_s;
            end else begin
                p1_tag_r  <= p1_tag_r;
                p1_term_r <= p1_term_r;
            end
        end
    end

    // Stage 2: accumulate; slot 0 restarts the sum, slot 3 publishes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r   <= 15'sd0;
            sound_r <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (p1_v_r) begin
                case (p1_tag_r)
                    2'd0: begin
                        acc_r <= {{2{p1_term_r[12]}}, p1_term_r};
                    end
                    2'd1, 2'd2: begin
                        acc_r <= sum_s;
                    end
                    2'd3: begin
                        sound_r <= sat(sum_s);
                        valid_r <= 1'b1;
                        acc_r   <= 15'sd0;
                    end
                    default: begin
                        acc_r <= acc_r;
                    end
                endcase
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    assign ch_idx       = ch_idx_r;
    assign sound        = sound_r;
    assign sample_valid = valid_r;

endmodule

// File: tb/tb_jt6295_mixer.sv
// Self-checking bench for jt6295_mixer: OUTW=12 and OUTW=14 instances share
// stimulus; a period-level model predicts every published sample and its cycle.
module tb_jt6295_mixer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen_sr4 = 1'b0;
    logic        cen_sr = 1'b0;
    logic [11:0] ch_sample = 12'd0;
    logic [3:0]  ch_att = 4'd0;
    logic        ch_active = 1'b0;

    logic [1:0]  ch_idx12, ch_idx14;
    logic [11:0] sound12;
    logic [13:0] sound14;
    logic        valid12, valid14;

    jt6295_mixer #(.OUTW(12)) u12 (
        .clk(clk), .rst(rst), .cen_sr4(cen_sr4), .cen_sr(cen_sr),
        .ch_sample(ch_sample), .ch_att(ch_att), .ch_active(ch_active),
        .ch_idx(ch_idx12), .sound(sound12), .sample_valid(valid12)
    );

    jt6295_mixer #(.OUTW(14)) u14 (
        .clk(clk), .rst(rst), .cen_sr4(cen_sr4), .cen_sr(cen_sr),
        .ch_sample(ch_sample), .ch_att(ch_att), .ch_active(ch_active),
        .ch_idx(ch_idx14), .sound(sound14), .sample_valid(valid14)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int val;
        bit is_rst;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    int  n_pulses = 0;
    bit  chk_en = 1'b0;
    int  hold12 = 0;
    int  hold14 = 0;
    int  m_idx = 0;
    int  m_sum = 0;
    int  gtab [16] = '{32, 22, 16, 11, 8, 6, 4, 3, 2, 0, 0, 0, 0, 0, 0, 0};

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int fdiv32(input int p);
        if (p >= 0) return p / 32;
        return -((-p + 31) / 32);
    endfunction

    function automatic int satw(input int v, input int w);
        int mx;
        mx = (1 << (w - 1)) - 1;
        if (v > mx) return mx;
        if (v < -mx - 1) return -mx - 1;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison of both instances against the expected event queue.
    always @(negedge clk) begin
        bit exp_v;
        exp_v = 1'b0;
        if (valid12) n_pulses++;
        if (chk_en) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                if (q[0].is_rst) begin
                    hold12 = 0;
                    hold14 = 0;
                end else begin
                    exp_v  = 1'b1;
                    hold12 = satw(q[0].val, 12);
                    hold14 = satw(q[0].val, 14);
                end
                void'(q.pop_front());
            end
            chk("valid12", int'(valid12), int'(exp_v));
            chk("valid14", int'(valid14), int'(exp_v));
            chk("sound12", int'($signed(sound12)), hold12);
            chk("sound14", int'($signed(sound14)), hold14);
        end
    end

    // One clock of stimulus; a strobe also advances the model.
    task automatic step(input bit stb, input bit sr, input int s, input int a, input bit act);
        int slot, t;
        cen_sr4   = stb;
        cen_sr    = sr;
        ch_sample = 12'(s);
        ch_att    = 4'(a);
        ch_active = act;
        if (stb) begin
            slot  = sr ? 0 : m_idx;
            m_idx = (slot + 1) % 4;
            t     = act ? fdiv32(s * gtab[a]) : 0;
            if (slot == 0) begin
                m_sum = t;
            end else if (slot < 3) begin
                m_sum = m_sum + t;
            end else begin
                q.push_back('{cyc + 2, m_sum + t, 1'b0});
                m_sum = 0;
            end
        end
        @(posedge clk);
        #1;
        if (stb) begin
            chk("ch_idx12", int'(ch_idx12), m_idx);
            chk("ch_idx14", int'(ch_idx14), m_idx);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, ($urandom_range(1) == 1), int'($urandom_range(4095)) - 2048,
                 int'($urandom_range(15)), ($urandom_range(1) == 1));
        end
    endtask

    task automatic do_rst();
        rst     = 1'b1;
        cen_sr4 = ($urandom_range(1) == 1);
        cen_sr  = ($urandom_range(1) == 1);
        while (q.size() > 0 && q[$].cyc >= cyc + 1) void'(q.pop_back());
        q.push_back('{cyc + 1, 0, 1'b1});
        m_sum = 0;
        m_idx = 0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        cen_sr4 = 1'b0;
        chk("rst_ch_idx", int'(ch_idx12), 0);
    endtask

    // Four strobes, the first with cen_sr; sample i = base + i*inc.
    task automatic period(input int base, input int inc, input int a, input int mask, input int gap);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 0), base + i * inc, a, mask[i]);
            if (i < 3) idle(gap);
        end
        idle(3);
    endtask

    initial begin
        int pulses0;
        int pos;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_sound", int'($signed(sound12)), 0);
        chk("reset_valid", int'(valid12), 0);
        chk("reset_ch_idx", int'(ch_idx12), 0);

        pulses0 = n_pulses;
        period(100, 100, 0, 4'hF, 1);
        chk("pin_sum_1000", int'($signed(sound12)), 1000);
        chk("pin_one_pulse", n_pulses - pulses0, 1);

        period(-1, 0, 1, 4'hF, 0);
        chk("pin_floor_m4", int'($signed(sound12)), -4);

        period(2047, 0, 2, 4'hF, 2);
        chk("pin_sat_hi12", int'($signed(sound12)), 2047);
        chk("pin_hi14", int'($signed(sound14)), 4092);

        period(-2048, 0, 0, 4'hF, 0);
        chk("pin_sat_lo12", int'($signed(sound12)), -2048);
        chk("pin_sat_lo14", int'($signed(sound14)), -8192);

        period(500, 0, 0, 4'b0101, 1);
        chk("pin_inactive", int'($signed(sound12)), 1000);
        period(500, 0, 12, 4'hF, 0);
        chk("pin_muted", int'($signed(sound12)), 0);

        // Resync: cen_sr on the third strobe truncates the period.
        pulses0 = n_pulses;
        step(1'b1, 1'b1, 700, 0, 1'b1);
        step(1'b1, 1'b0, 700, 0, 1'b1);
        step(1'b1, 1'b1, 700, 0, 1'b1);
        step(1'b1, 1'b0, 700, 0, 1'b1);
        idle(3);
        chk("pin_trunc_nopulse", n_pulses - pulses0, 0);
        period(10, 10, 0, 4'hF, 0);
        chk("pin_after_resync", int'($signed(sound12)), 100);

        // Reset between strobes 2 and 3.
        step(1'b1, 1'b1, 900, 0, 1'b1);
        step(1'b1, 1'b0, 900, 0, 1'b1);
        do_rst();
        #5;
        chk("pin_rst_sound", int'($signed(sound12)), 0);
        chk("pin_rst_valid", int'(valid12), 0);
        idle(1);
        period(1, 1, 0, 4'hF, 0);
        chk("pin_after_rst", int'($signed(sound12)), 10);

        // Randomized traffic with occasional early resync and reset.
        pos = 0;
        for (int k = 0; k < 600; k++) begin
            bit sr;
            if ($urandom_range(59) == 0) begin
                do_rst();
                pos = 0;
            end
            sr = (pos == 0) || ($urandom_range(24) == 0);
            if (sr) pos = 0;
            step(1'b1, sr, int'($urandom_range(4095)) - 2048, int'($urandom_range(15)),
                 ($urandom_range(7) != 0));
            pos = (pos + 1) % 4;
            idle(int'($urandom_range(2)));
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
